// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_tx
//  Description : FIFO-buffered stereo I2S / left-justified transmitter.
//                Stereo frames enter a small FIFO through a valid/ready
//                handshake. They are serialised MSB-first onto the codec
//                pins. MCLK, SCLK and LRCK are divided from i_clock by
//                counters, so the block has no derived clock domains.
//
//  Ports       : i_clock, i_reset      - system clock, sync active-high reset
//                i_valid / o_ready     - frame push handshake
//                i_left, i_right       - two's complement channel samples
//                o_level               - frames currently buffered
//                o_underrun            - 1-cycle pulse, frame start found FIFO empty
//                o_i2s_mclk/sclk/lrck  - codec clocks (lrck 0 = left slot)
//                o_i2s_sdout           - serial data, changes on SCLK fall
//
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_tx #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int SLOT_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int SCLK_HALF      = 16,
    parameter int MCLK_HALF      = 4,
    parameter bit LEFT_JUSTIFIED = 1'b0
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [SAMPLE_WIDTH-1:0]       i_left,
    input  logic [SAMPLE_WIDTH-1:0]       i_right,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underrun,
    output logic                          o_i2s_mclk,
    output logic                          o_i2s_sclk,
    output logic                          o_i2s_lrck,
    output logic                          o_i2s_sdout
);

    localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W      = c_PTR_W + 1;
    localparam int c_FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS);
    localparam int c_SCLK_W     = $clog2(SCLK_HALF);
    localparam int c_MCLK_W     = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    // Data lags LRCK by one SCLK in I2S mode, none when left-justified.
    localparam int c_DELAY      = LEFT_JUSTIFIED ? 0 : 1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_MCLK_W-1:0]     r_mclk_cnt;
    logic                    r_mclk;
    logic [c_SCLK_W-1:0]     r_sclk_cnt;
    logic                    r_sclk;
    logic [c_BIT_W-1:0]      r_bit;
    logic                    r_lrck;
    logic                    r_sdout;
    logic                    r_underrun;
    logic [SAMPLE_WIDTH-1:0] r_left;
    logic [SAMPLE_WIDTH-1:0] r_right;
    logic [SAMPLE_WIDTH-1:0] r_mem_left  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] r_mem_right [FIFO_DEPTH];
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_LVL_W-1:0]      r_level;
    logic                    r_ready;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                    w_fall;
    logic [c_BIT_W-1:0]      w_pos;
    logic                    w_right_ch;
    logic [c_BIT_W-1:0]      w_k;
    logic                    w_load;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [SAMPLE_WIDTH-1:0] w_new_left;
    logic [SAMPLE_WIDTH-1:0] w_new_right;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic [c_BIT_W-1:0]      w_idx;
    logic [SAMPLE_WIDTH-1:0] w_mask;
    logic                    w_bit;
    logic [c_LVL_W-1:0]      w_level_next;

    // The fall event is the cycle whose edge registers sclk 1 -> 0.
    assign w_fall  = r_sclk && (r_sclk_cnt == c_SCLK_W'(SCLK_HALF - 1));
    assign w_empty = (r_level == '0);
    assign w_push  = i_valid && r_ready;

    always_comb begin
        // Slot position of the bit being emitted, shifted back by the data delay.
        if ((c_DELAY != 0) && (r_bit == '0)) begin
            w_pos = c_BIT_W'(c_FRAME_BITS - 1);
        end else begin
            w_pos = r_bit - c_BIT_W'(c_DELAY);
        end

        w_right_ch = (w_pos >= c_BIT_W'(SLOT_WIDTH));
        w_k        = w_right_ch ? (w_pos - c_BIT_W'(SLOT_WIDTH)) : w_pos;
        w_load     = w_fall && (w_pos == '0);
        w_pop      = w_load && !w_empty;

        w_new_left  = w_empty ? '0 : r_mem_left[r_rd_ptr];
        w_new_right = w_empty ? '0 : r_mem_right[r_rd_ptr];

        // On the load edge the fresh frame's left MSB goes out immediately.
        if (w_right_ch) begin
            w_word = r_right;
        end else if (w_load) begin
            w_word = w_new_left;
        end else begin
            w_word = r_left;
        end

        w_idx  = c_BIT_W'(SAMPLE_WIDTH - 1) - w_k;
        w_mask = {{(SAMPLE_WIDTH-1){1'b0}}, 1'b1} << w_idx;
        w_bit  = (w_k < c_BIT_W'(SAMPLE_WIDTH)) ? |(w_word & w_mask) : 1'b0;

        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + c_LVL_W'(1);
            2'b01:   w_level_next = r_level - c_LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // ------------------------------------------------------------------
    // Clock dividers, bit counter and serial output
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mclk_cnt <= '0;
            r_mclk     <= 1'b0;
            r_sclk_cnt <= '0;
            r_sclk     <= 1'b0;
            r_bit      <= '0;
            r_lrck     <= 1'b0;
            r_sdout    <= 1'b0;
            r_underrun <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
        end else begin
            if (r_mclk_cnt == c_MCLK_W'(MCLK_HALF - 1)) begin
                r_mclk_cnt <= '0;
                r_mclk     <= ~r_mclk;
            end else begin
                r_mclk_cnt <= r_mclk_cnt + c_MCLK_W'(1);
            end

            if (r_sclk_cnt == c_SCLK_W'(SCLK_HALF - 1)) begin
                r_sclk_cnt <= '0;
                r_sclk     <= ~r_sclk;
            end else begin
                r_sclk_cnt <= r_sclk_cnt + c_SCLK_W'(1);
            end

            r_underrun <= w_load && w_empty;

            if (w_fall) begin
                r_bit   <= (r_bit == c_BIT_W'(c_FRAME_BITS - 1)) ? '0 : r_bit + c_BIT_W'(1);
                r_lrck  <= (r_bit >= c_BIT_W'(SLOT_WIDTH));
                r_sdout <= w_bit;
            end

            // A starved frame is sent as silence.
            if (w_load) begin
                r_left  <= w_new_left;
                r_right <= w_new_right;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_left[r_wr_ptr]  <= i_left;
            r_mem_right[r_wr_ptr] <= i_right;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= w_level_next;
            // Registered from the next level so ready never lags occupancy.
            r_ready <= (w_level_next < c_LVL_W'(FIFO_DEPTH));
        end
    end

    assign o_ready     = r_ready;
    assign o_level     = r_level;
    assign o_underrun  = r_underrun;
    assign o_i2s_mclk  = r_mclk;
    assign o_i2s_sclk  = r_sclk;
    assign o_i2s_lrck  = r_lrck;
    assign o_i2s_sdout = r_sdout;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_i2s_tx
//  Description : Self-checking bench for audio_i2s_tx. Three instances:
//                0 = I2S 16/32, 1 = left-justified 16/32, 2 = I2S 24/24.
//                A time-based behavioural model predicts every output on
//                every cycle; directed phases pin literal waveforms.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_i2s_tx;

    localparam int SH    = 2;
    localparam int MH    = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] l16, r16;
    logic [23:0] l24, r24;
    logic [2:0]  rdy, und, mclk, sclk, lrck, sd;
    logic [3:0]  lvl0, lvl1, lvl2;

    always #5 clk = ~clk;

    audio_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(DEPTH), .SCLK_HALF(SH),
                   .MCLK_HALF(MH), .LEFT_JUSTIFIED(1'b0)) u_i2s (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(rdy[0]),
        .i_left(l16), .i_right(r16), .o_level(lvl0), .o_underrun(und[0]),
        .o_i2s_mclk(mclk[0]), .o_i2s_sclk(sclk[0]), .o_i2s_lrck(lrck[0]), .o_i2s_sdout(sd[0]));

    audio_i2s_tx #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .FIFO_DEPTH(DEPTH), .SCLK_HALF(SH),
                   .MCLK_HALF(MH), .LEFT_JUSTIFIED(1'b1)) u_lj (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(rdy[1]),
        .i_left(l16), .i_right(r16), .o_level(lvl1), .o_underrun(und[1]),
        .o_i2s_mclk(mclk[1]), .o_i2s_sclk(sclk[1]), .o_i2s_lrck(lrck[1]), .o_i2s_sdout(sd[1]));

    audio_i2s_tx #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24), .FIFO_DEPTH(DEPTH), .SCLK_HALF(SH),
                   .MCLK_HALF(MH), .LEFT_JUSTIFIED(1'b0)) u_w24 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .o_ready(rdy[2]),
        .i_left(l24), .i_right(r24), .o_level(lvl2), .o_underrun(und[2]),
        .o_i2s_mclk(mclk[2]), .o_i2s_sclk(sclk[2]), .o_i2s_lrck(lrck[2]), .o_i2s_sdout(sd[2]));

    // Per-instance configuration
    int cfg_sw   [3] = '{16, 16, 24};
    int cfg_slot [3] = '{32, 32, 24};
    int cfg_d    [3] = '{1, 0, 1};
    int cap_max  [3] = '{64, 64, 49};

    int errors = 0;
    int checks = 0;

    // Model state
    int          t_m;
    int          cnt_m [3];
    int          hd_m  [3];
    logic [23:0] fl_m  [3][DEPTH];
    logic [23:0] fr_m  [3][DEPTH];
    logic [23:0] cl_m  [3];
    logic [23:0] cr_m  [3];
    logic        lr_m  [3];
    logic        sd_m  [3];
    logic        un_m  [3];
    logic        rdy_m [3];

    // Directed-phase observation
    logic        cap_en, und_en;
    logic [63:0] cap_sd [3];
    logic [63:0] cap_lr [3];
    int          cap_n  [3];
    logic        prev_sclk [3];
    int          und_t  [3][2];
    int          und_n  [3];

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0d: got %0h, expected %0h", nm, id, t_m, act, exp);
        end
    endtask

    function automatic logic [3:0] lvl_of(input int id);
        case (id)
            0:       return lvl0;
            1:       return lvl1;
            default: return lvl2;
        endcase
    endfunction

    // Model update on each edge, then compare shortly after.
    always @(posedge clk) begin : p_model
        int          S, W, D, b, p, k, tail;
        logic        pop, push;
        logic [23:0] inl, inr;
        if (rst) begin
            t_m = 0;
            for (int id = 0; id < 3; id++) begin
                cnt_m[id] = 0; hd_m[id] = 0; cl_m[id] = '0; cr_m[id] = '0;
                lr_m[id] = 1'b0; sd_m[id] = 1'b0; un_m[id] = 1'b0; rdy_m[id] = 1'b0;
                cap_sd[id] = '0; cap_lr[id] = '0; cap_n[id] = 0;
                und_n[id] = 0; und_t[id][0] = -1; und_t[id][1] = -1;
            end
        end else begin
            t_m = t_m + 1;
            for (int id = 0; id < 3; id++) begin
                S = cfg_slot[id]; W = cfg_sw[id]; D = cfg_d[id];
                inl = (id == 2) ? l24 : {8'h00, l16};
                inr = (id == 2) ? r24 : {8'h00, r16};
                push = valid && rdy_m[id];
                pop = 1'b0;
                un_m[id] = 1'b0;
                tail = (hd_m[id] + cnt_m[id]) % DEPTH;
                if (t_m % (2*SH) == 0) begin
                    b = (t_m / (2*SH) - 1) % (2*S);
                    lr_m[id] = (b >= S);
                    p = (b - D + 2*S) % (2*S);
                    if (p == 0) begin
                        if (cnt_m[id] > 0) begin
                            cl_m[id] = fl_m[id][hd_m[id]];
                            cr_m[id] = fr_m[id][hd_m[id]];
                            pop = 1'b1;
                        end else begin
                            cl_m[id] = '0; cr_m[id] = '0;
                            un_m[id] = 1'b1;
                        end
                    end
                    k = p % S;
                    if (k < W) sd_m[id] = (p < S) ? cl_m[id][W-1-k] : cr_m[id][W-1-k];
                    else       sd_m[id] = 1'b0;
                end
                if (pop) hd_m[id] = (hd_m[id] + 1) % DEPTH;
                if (push) begin
                    fl_m[id][tail] = inl;
                    fr_m[id][tail] = inr;
                end
                cnt_m[id] = cnt_m[id] + (push ? 1 : 0) - (pop ? 1 : 0);
                rdy_m[id] = (cnt_m[id] < DEPTH);
            end
        end
        #1;
        for (int id = 0; id < 3; id++) begin
            chk("ready",    id, 64'(rdy[id]),    64'(rdy_m[id]));
            chk("level",    id, 64'(lvl_of(id)), 64'(cnt_m[id]));
            chk("underrun", id, 64'(und[id]),    64'(un_m[id]));
            chk("mclk",     id, 64'(mclk[id]),   64'((t_m / MH) % 2));
            chk("sclk",     id, 64'(sclk[id]),   64'((t_m / SH) % 2));
            chk("lrck",     id, 64'(lrck[id]),   64'(lr_m[id]));
            chk("sdout",    id, 64'(sd[id]),     64'(sd_m[id]));
            if (cap_en && prev_sclk[id] && !sclk[id] && cap_n[id] < cap_max[id]) begin
                cap_sd[id] = {cap_sd[id][62:0], sd[id]};
                cap_lr[id] = {cap_lr[id][62:0], lrck[id]};
                cap_n[id]  = cap_n[id] + 1;
            end
            prev_sclk[id] = sclk[id];
            if (und_en && und[id] && und_n[id] < 2) begin
                und_t[id][und_n[id]] = t_m;
                und_n[id] = und_n[id] + 1;
            end
        end
    end

    task automatic wait_t(input int target);
        while (t_m < target) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int thr [4] = '{50, 2, 300, 20};
        rst = 1'b1; valid = 1'b0; cap_en = 1'b0; und_en = 1'b0;
        l16 = '0; r16 = '0; l24 = '0; r24 = '0;
        for (int id = 0; id < 3; id++) prev_sclk[id] = 1'b0;

        // Phase 1: single frame, literal waveforms for all three formats
        repeat (3) @(negedge clk);
        cap_en = 1'b1;
        rst = 1'b0;
        wait_t(1);
        valid = 1'b1; l16 = 16'hA5C3; r16 = 16'h1234; l24 = 24'h800001; r24 = 24'hC00001;
        @(negedge clk);
        valid = 1'b0;
        wait_t(300);
        cap_en = 1'b0;
        chk("i2s_frame_bits", 0, cap_sd[0], {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h1234, 15'h0});
        chk("i2s_frame_lrck", 0, cap_lr[0], {32'h0, 32'hFFFF_FFFF});
        chk("lj_frame_bits",  1, cap_sd[1], {16'hA5C3, 16'h0, 16'h1234, 16'h0});
        chk("lj_frame_lrck",  1, cap_lr[1], {32'h0, 32'hFFFF_FFFF});
        chk("w24_frame_bits", 2, cap_sd[2], 64'({1'b0, 24'h800001, 24'hC00001}));

        // Phase 2: no pushes, underrun cadence
        und_en = 1'b1;
        do_reset();
        wait_t(540);
        und_en = 1'b0;
        chk("underrun_first",  0, 64'(und_t[0][0]), 64'(8));
        chk("underrun_second", 0, 64'(und_t[0][1]), 64'(264));
        chk("underrun_first",  1, 64'(und_t[1][0]), 64'(4));
        chk("underrun_second", 1, 64'(und_t[1][1]), 64'(260));
        chk("underrun_first",  2, 64'(und_t[2][0]), 64'(8));
        chk("underrun_second", 2, 64'(und_t[2][1]), 64'(200));

        // Phase 3: overfill
        do_reset();
        wait_t(9);
        valid = 1'b1;
        repeat (9) begin
            l16 = 16'($urandom); r16 = 16'($urandom); l24 = 24'($urandom); r24 = 24'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        wait_t(20);
        chk("full_level", 0, 64'(lvl0), 64'(8));
        chk("full_ready", 0, 64'(rdy[0]), 64'(0));
        chk("full_level", 1, 64'(lvl1), 64'(8));
        chk("full_level", 2, 64'(lvl2), 64'(8));
        wait_t(264);
        chk("after_pop_level", 0, 64'(lvl0), 64'(7));
        chk("after_pop_ready", 0, 64'(rdy[0]), 64'(1));
        chk("after_pop_level", 1, 64'(lvl1), 64'(7));
        chk("after_pop_level", 2, 64'(lvl2), 64'(7));

        // Phase 4: push coinciding with pop, then reset mid right slot
        do_reset();
        wait_t(1);
        valid = 1'b1; l16 = 16'h0F0F; r16 = 16'hFFFF; l24 = 24'h123456; r24 = 24'h654321;
        @(negedge clk);
        valid = 1'b0;
        wait_t(7);
        chk("pre_pushpop_level", 0, 64'(lvl0), 64'(1));
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("pushpop_level", 0, 64'(lvl0), 64'(1));
        chk("pushpop_level", 1, 64'(lvl1), 64'(1));
        wait_t(150);
        chk("right_slot_sdout", 0, 64'(sd[0]), 64'(1));
        chk("right_slot_lrck",  0, 64'(lrck[0]), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("reset_pins",  0, 64'({mclk[0], sclk[0], lrck[0], sd[0], und[0]}), 64'(0));
        chk("reset_level", 0, 64'(lvl0), 64'(0));
        chk("reset_ready", 0, 64'(rdy[0]), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Phase 5: randomized traffic at several fill rates
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1200; c++) begin
                valid = ($urandom_range(0, thr[seg] - 1) == 0);
                l16 = 16'($urandom); r16 = 16'($urandom);
                l24 = 24'($urandom); r24 = 24'($urandom);
                rst = (seg == 2 && (c == 600 || c == 601));
                @(negedge clk);
            end
        end
        valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
